// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: groups the dump request, register-file read port and output word channel
// master: the requester/consumer/register-file side; slave: the dump reader itself
// start/abort/first_reg/last_reg    : dump request and range
// rf_read_reg/rf_read_data          : combinational register-file read port
// out_valid/out_ready/out_data/out_index : dumped word handshake
// busy/done/error                   : status
interface regfile_dump_reader_if #(parameter int DATA_W = 32);
    logic              start;
    logic              abort;
    logic [4:0]        first_reg;
    logic [4:0]        last_reg;
    logic [4:0]        rf_read_reg;
    logic [DATA_W-1:0] rf_read_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_index;
    logic              busy;
    logic              done;
    logic              error;
    modport master (
        output start, abort, first_reg, last_reg, rf_read_data, out_ready,
        input  rf_read_reg, out_valid, out_data, out_index, busy, done, error
    );
    modport slave (
        input  start, abort, first_reg, last_reg, rf_read_data, out_ready,
        output rf_read_reg, out_valid, out_data, out_index, busy, done, error
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams registers first_reg..last_reg out of a register file, one word per handshake
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : regfile_dump_reader_if.slave (request, register-file read port, output word channel, status)
// Optional build macro DUMP_SKIP_X0_EN: never emit index 0 (x0 is skipped without a word)
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input logic clk,
    input logic reset,
    regfile_dump_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
    state_t state, state_nx;
    logic [4:0]        idx, end_idx, index_q, start_idx;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, error_q, range_ok, accept, hs, empty;
    assign range_ok = bus.first_reg <= bus.last_reg && int'(bus.last_reg) < NUM_REGS;
    assign accept   = state == IDLE && bus.start && range_ok;
    assign hs       = valid_q && bus.out_ready;
`ifdef DUMP_SKIP_X0_EN
    // x0 is stepped over at acceptance; idx+1 can never return to 0, so this is the only place it matters
    assign start_idx = bus.first_reg == 5'd0 ? 5'd1 : bus.first_reg;
    assign empty     = bus.first_reg == 5'd0 && bus.last_reg == 5'd0;
`else
    assign start_idx = bus.first_reg;
    assign empty     = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = empty ? DONE : READ;
            READ: state_nx = bus.abort ? DONE : HOLD;
            HOLD: if (bus.abort) state_nx = DONE;
                  else if (hs) state_nx = idx == end_idx ? DONE : READ;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            end_idx <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            error_q <= state == IDLE && bus.start && !range_ok;
            if (accept) end_idx <= bus.last_reg;
            if (accept && !empty) idx <= start_idx;
            if (state == READ && !bus.abort) begin
                data_q  <= bus.rf_read_data;
                index_q <= idx;
            end
            // abort wins over a simultaneous handshake and drops the word
            valid_q <= (state == READ && !bus.abort) || (state == HOLD && !bus.abort && !hs);
            if (state == HOLD && !bus.abort && hs && idx != end_idx) idx <= idx + 5'd1;
        end
    end
    assign bus.rf_read_reg = state == READ ? idx : 5'd0;
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.out_index   = index_q;
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.error       = error_q;
endmodule
